// File: rtl/sub_byte_seq.sv
// Iterative forward AES SubBytes: substitutes BYTES_PER_CYCLE bytes of a 128-bit
// state per clock through a shared S-box slice, most significant chunk first.
module sub_byte_seq #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clock50MHz,
    input  logic         reset,
    input  logic         startTransition,
    input  logic [127:0] inputData,
    output logic         ready,
    output logic         outputValid,
    output logic [127:0] outputData,
    output logic         debugState
);
    // Handshake: a block is accepted on any rising edge where startTransition and
    // ready are both high; outputValid is a one-cycle pulse with no back-pressure.

    localparam int NUM_CHUNKS = 16 / BYTES_PER_CYCLE;
    localparam int CHUNK_BITS = 8 * BYTES_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : genBadParam
            $error("sub_byte_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // FIPS-197 forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // 2047 - 8*b folds into inverting the byte and appending ones.
        return SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} seqState_t;

    seqState_t             state, nextState;
    logic [CNT_W-1:0]      chunkCount;
    logic [127:0]          workReg, workNext;
    logic [CHUNK_BITS-1:0] chunkIn, chunkOut;
    logic [6:0]            chunkLsb;
    logic                  lastStep, loadWork, stepWork;

    assign lastStep = (chunkCount == LAST_CHUNK);

    always_ff @(posedge clock50MHz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (startTransition) nextState = BUSY;
            BUSY: if (lastStep)        nextState = IDLE;
        endcase
    end

    always_comb begin
        ready      = (state == IDLE);
        debugState = (state == BUSY);
        loadWork   = (state == IDLE) && startTransition;
        stepWork   = (state == BUSY);
    end

    // Chunk 0 is the most significant slice of the working register.
    always_comb begin
        chunkLsb = 7'((NUM_CHUNKS - 1 - int'(chunkCount)) * CHUNK_BITS);
        chunkIn  = workReg[chunkLsb +: CHUNK_BITS];
        chunkOut = '0;
        for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
            chunkOut[8*i +: 8] = sbox(chunkIn[8*i +: 8]);
        end
        workNext = workReg;
        workNext[chunkLsb +: CHUNK_BITS] = chunkOut;
    end

    always_ff @(posedge clock50MHz or posedge reset) begin
        if (reset) begin
            workReg     <= '0;
            chunkCount  <= '0;
            outputData  <= '0;
            outputValid <= 1'b0;
        end else begin
            outputValid <= 1'b0;
            if (loadWork) begin
                workReg    <= inputData;
                chunkCount <= '0;
            end else if (stepWork) begin
                workReg <= workNext;
                if (lastStep) begin
                    outputData  <= workNext;
                    outputValid <= 1'b1;
                    chunkCount  <= '0;
                end else begin
                    chunkCount <= chunkCount + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sub_byte_seq.md
Name: sub_byte_seq

Overview:
- Iterative forward AES SubBytes engine for the encryption datapath; the forward counterpart of the combinational inverse substitution block used in decryption.
- Accepts a 128-bit state on a start handshake and substitutes BYTES_PER_CYCLE bytes per clock through a shared forward S-box array.
- Returns the full substituted state with a one-cycle valid pulse, trading latency for S-box area. Sits between AddRoundKey and ShiftRows in the round controller.

Parameters:
BYTES_PER_CYCLE, 1, bytes substituted per clock; legal values 1, 2, 4, 8, 16; other values are a compile-time error.

Ports:
clock50MHz  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
startTransition  input  1  request; sampled only while ready=1
inputData  input  128  state to substitute, byte 15 = bits [127:120]
ready  output  1  high when idle and able to accept startTransition
outputValid  output  1  one-cycle pulse, outputData newly updated
outputData  output  128  substituted state, held until next completion

Behaviour:
- Reset (async assert, any state): state=IDLE, ready=1, outputValid=0, outputData=0, chunk counter=0, working register=0.
- States: IDLE, BUSY. No other states.
- IDLE: ready=1. On a rising edge with startTransition=1, latch inputData into the working register, set counter=0 and go to BUSY. ready drops the cycle after acceptance.
- BUSY: ready=0. Each rising edge replaces chunk[counter] of the working register with its S-box image. Chunks are processed MSB first: chunk 0 = bytes [127 : 128-8*BYTES_PER_CYCLE]. Counter increments by 1 per edge.
- Completion: on the edge that writes the last chunk (counter = 16/BYTES_PER_CYCLE-1):
  - outputData <= fully substituted value
  - outputValid <= 1 for exactly one cycle
  - state returns to IDLE, counter=0
- Latency: outputValid is high 16/BYTES_PER_CYCLE cycles after the accepting edge (16 cycles for N=1, 1 cycle for N=16).
- Throughput: one block per 16/N + 1 cycles when startTransition is held high.
- startTransition during BUSY is ignored, with no queuing. The inputData value is captured only on the accepting edge; later changes have no effect.
- startTransition high in the cycle outputValid is high: ready=1 in that cycle, so the request is accepted normally.
- outputData is unchanged from completion until the next completion or reset. It is never partially updated.
- Reset asserted mid-BUSY: the block aborts immediately, no outputValid is produced, and outputData is cleared to 0.
- S-box: the standard FIPS-197 forward table, purely combinational per byte, with BYTES_PER_CYCLE instances. Each byte maps independently, with no carry or width growth.

Test Plan:
- N=1, reset then start with inputData=128'h432eca169e44944515bfb66dfdd7cb52 -> outputValid pulses exactly 16 cycles after the accepting edge, outputData=128'h1a3174470b1b226e59084e3c540e1f00, ready=0 for those 16 cycles.
- N=16, inputData=0 -> outputValid 1 cycle after acceptance, outputData=128'h6363...63 (16 bytes of 63). Then inputData=all ff -> 16 bytes of 16.
- N=4, start pulses on every BUSY cycle plus inputData changed mid-operation -> exactly one outputValid, with the result computed from the originally captured value.
- N=1, startTransition held high continuously with alternating vectors 0 / 128'h53535...53 -> results 6363..63 and eded..ed in order, period 17 cycles, no lost or duplicated pulses.
- N=2, assert reset on cycle 4 of BUSY -> outputValid never pulses, outputData=0, ready=1 immediately. A new start after release completes correctly in 8 cycles.
- Hold check: after any completion, outputData stays stable across 100 idle cycles with inputData toggling.
